// File: rtl/flag_counter_sequencer.sv
// Moore controller that runs one FlagCounter through a cleared, two-phase measurement.
// Each phase is guarded by a watchdog, and completed runs are counted.
module flag_counter_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int WD_W    = 7,
    parameter int RC_W    = 8
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            hold_i,
    input  logic            s1_i,
    input  logic            s2_i,
    output logic            en_o,
    output logic            cntClr_o,
    output logic [1:0]      phase_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            timeout_o,
    output logic [RC_W-1:0] runCount_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN1  = 3'd2,
        RUN2  = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } state_t;

    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    state_t            stateQ, stateD;
    logic [WD_W-1:0]   wdQ, wdD;
    logic [RC_W-1:0]   runCountQ, runCountD;
    logic              enQ, enD;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stateQ    <= IDLE;
            wdQ       <= '0;
            runCountQ <= '0;
            enQ       <= 1'b0;
        end else begin
            stateQ    <= stateD;
            wdQ       <= wdD;
            runCountQ <= runCountD;
            enQ       <= enD;
        end
    end

    // Abort outranks flags and the watchdog; a held cycle leaves the watchdog untouched.
    always_comb begin
        stateD    = stateQ;
        wdD       = wdQ;
        runCountD = runCountQ;
        if (abort_i) begin
            stateD = IDLE;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (start_i) stateD = CLEAR;
                end
                CLEAR: begin
                    stateD = RUN1;
                    wdD    = WD_LOAD;
                end
                RUN1: begin
                    if (s2_i) begin
                        stateD = DONE;
                    end else if (s1_i) begin
                        stateD = RUN2;
                        wdD    = WD_LOAD;
                    end else if (!hold_i) begin
                        if (wdQ == WD_ONE) stateD = FAULT;
                        else               wdD    = wdQ - WD_ONE;
                    end
                end
                RUN2: begin
                    if (s2_i) begin
                        stateD = DONE;
                    end else if (!hold_i) begin
                        if (wdQ == WD_ONE) stateD = FAULT;
                        else               wdD    = wdQ - WD_ONE;
                    end
                end
                DONE:    stateD = IDLE;
                FAULT:   stateD = FAULT;
                default: stateD = IDLE;
            endcase
        end
        if (stateD == DONE) runCountD = runCountQ + 1'b1;
    end

    // EN is registered from the next state so no input reaches an output combinationally.
    always_comb begin
        enD = ((stateD == RUN1) || (stateD == RUN2)) && !hold_i;
    end

    assign en_o       = enQ;
    assign cntClr_o   = (stateQ == CLEAR);
    assign phase_o    = (stateQ == RUN1) ? 2'b01 : ((stateQ == RUN2) ? 2'b10 : 2'b00);
    assign busy_o     = (stateQ == CLEAR) || (stateQ == RUN1) || (stateQ == RUN2);
    assign done_o     = (stateQ == DONE);
    assign timeout_o  = (stateQ == FAULT);
    assign runCount_o = runCountQ;

endmodule

// File: tb/tb_flag_counter_sequencer.sv
// Directed, table-driven bench for flag_counter_sequencer (TIMEOUT=8).
// Expected outputs are packed as {en, cntClr, phase, busy, done, timeout, runCount}.
module tb_flag_counter_sequencer;

    localparam int TIMEOUT = 8;
    localparam int WD_W    = 4;
    localparam int RC_W    = 8;

    typedef struct {
        logic start, abort, hold, s1, s2;
        logic [14:0] expOut;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset, start, abort, hold, s1, s2;
    logic            en, cntClr, busy, done, timeoutFlag;
    logic [1:0]      phase;
    logic [RC_W-1:0] runCount;

    int assertions = 0;
    int failures   = 0;
    vec_t vecs[$];

    flag_counter_sequencer #(.TIMEOUT(TIMEOUT), .WD_W(WD_W), .RC_W(RC_W)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort), .hold_i(hold),
        .s1_i(s1), .s2_i(s2), .en_o(en), .cntClr_o(cntClr), .phase_o(phase),
        .busy_o(busy), .done_o(done), .timeout_o(timeoutFlag), .runCount_o(runCount)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] packExp(input logic e, input logic c, input logic [1:0] p,
                                            input logic b, input logic d, input logic t,
                                            input logic [7:0] rc);
        return {e, c, p, b, d, t, rc};
    endfunction

    function automatic vec_t mkVec(input logic st, input logic ab, input logic hd, input logic f1,
                                   input logic f2, input logic [14:0] ex);
        vec_t v;
        v.start = st; v.abort = ab; v.hold = hd; v.s1 = f1; v.s2 = f2; v.expOut = ex;
        return v;
    endfunction

    task automatic applyStimulus(input logic rst, input logic st, input logic ab, input logic hd,
                                 input logic f1, input logic f2);
        reset = rst; start = st; abort = ab; hold = hd; s1 = f1; s2 = f2;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [14:0] expected);
        logic [14:0] actual;
        actual = {en, cntClr, phase, busy, done, timeoutFlag, runCount};
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got en=%b clr=%b ph=%b busy=%b done=%b to=%b rc=%0d, expected en=%b clr=%b ph=%b busy=%b done=%b to=%b rc=%0d",
                     name, actual[14], actual[13], actual[12:11], actual[10], actual[9], actual[8], actual[7:0],
                     expected[14], expected[13], expected[12:11], expected[10], expected[9], expected[8], expected[7:0]);
        end
    endtask

    initial begin
        logic [14:0] idle0, run1Exp;
        int enCount;
        int limit;
        bit sawFault;

        reset = 1'b1; start = 0; abort = 0; hold = 0; s1 = 0; s2 = 0;
        idle0 = packExp(0, 0, 2'b00, 0, 0, 0, 8'd0);

        // Reset held 3 cycles, then idle for 10 cycles.
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("reset", idle0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("idle_%0d", i), idle0);
        end

        // Full run, simultaneous flags, abort in RUN2, Start held through DONE.
        vecs.push_back(mkVec(1,0,0,0,0, packExp(0,1,2'b00,1,0,0,8'd0)));
        vecs.push_back(mkVec(0,0,0,0,0, packExp(1,0,2'b01,1,0,0,8'd0)));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mkVec(0,0,0,0,0, packExp(1,0,2'b01,1,0,0,8'd0)));
        vecs.push_back(mkVec(0,0,0,1,0, packExp(1,0,2'b10,1,0,0,8'd0)));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mkVec(0,0,0,0,0, packExp(1,0,2'b10,1,0,0,8'd0)));
        vecs.push_back(mkVec(0,0,0,0,1, packExp(0,0,2'b00,0,1,0,8'd1)));
        vecs.push_back(mkVec(0,0,0,0,0, packExp(0,0,2'b00,0,0,0,8'd1)));
        vecs.push_back(mkVec(1,0,0,0,0, packExp(0,1,2'b00,1,0,0,8'd1)));
        vecs.push_back(mkVec(0,0,0,0,0, packExp(1,0,2'b01,1,0,0,8'd1)));
        vecs.push_back(mkVec(0,0,0,1,1, packExp(0,0,2'b00,0,1,0,8'd2)));
        vecs.push_back(mkVec(0,0,0,0,0, packExp(0,0,2'b00,0,0,0,8'd2)));
        vecs.push_back(mkVec(1,0,0,0,0, packExp(0,1,2'b00,1,0,0,8'd2)));
        vecs.push_back(mkVec(0,0,0,0,0, packExp(1,0,2'b01,1,0,0,8'd2)));
        vecs.push_back(mkVec(0,0,0,1,0, packExp(1,0,2'b10,1,0,0,8'd2)));
        vecs.push_back(mkVec(0,1,0,0,1, packExp(0,0,2'b00,0,0,0,8'd2)));
        vecs.push_back(mkVec(0,0,0,0,0, packExp(0,0,2'b00,0,0,0,8'd2)));
        vecs.push_back(mkVec(1,0,0,0,0, packExp(0,1,2'b00,1,0,0,8'd2)));
        vecs.push_back(mkVec(1,0,0,0,0, packExp(1,0,2'b01,1,0,0,8'd2)));
        vecs.push_back(mkVec(1,0,0,0,1, packExp(0,0,2'b00,0,1,0,8'd3)));
        vecs.push_back(mkVec(1,0,0,0,0, packExp(0,0,2'b00,0,0,0,8'd3)));
        vecs.push_back(mkVec(1,0,0,0,0, packExp(0,1,2'b00,1,0,0,8'd3)));
        vecs.push_back(mkVec(0,1,0,0,0, packExp(0,0,2'b00,0,0,0,8'd3)));
        foreach (vecs[i]) begin
            applyStimulus(0, vecs[i].start, vecs[i].abort, vecs[i].hold, vecs[i].s1, vecs[i].s2);
            checkOutput($sformatf("vec_%0d", i), vecs[i].expOut);
        end

        // Watchdog: S1 never arrives, EN high for exactly TIMEOUT cycles.
        applyStimulus(0, 1, 0, 0, 0, 0);
        enCount = 0; sawFault = 0; limit = 0;
        while (!sawFault && limit < 30) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            if (en) enCount++;
            if (timeoutFlag) sawFault = 1;
            limit++;
        end
        assertions++;
        if (!sawFault || enCount != TIMEOUT) begin
            failures++;
            $display("[TB] FAIL watchdog_en_cycles: got %0d (fault=%0b), expected %0d (fault=1)", enCount, sawFault, TIMEOUT);
        end
        checkOutput("fault_state", packExp(0,0,2'b00,0,0,1,8'd3));
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("fault_ignores_start", packExp(0,0,2'b00,0,0,1,8'd3));
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("fault_abort", packExp(0,0,2'b00,0,0,0,8'd3));

        // Hold freezes the watchdog: 3 + 4 enabled cycles around a 5-cycle hold, then S1.
        run1Exp = packExp(1,0,2'b01,1,0,0,8'd3);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("hold_pre_%0d", i), run1Exp);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 0);
            checkOutput($sformatf("hold_on_%0d", i), packExp(0,0,2'b01,1,0,0,8'd3));
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("hold_post_%0d", i), run1Exp);
        end
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("hold_to_run2", packExp(1,0,2'b10,1,0,0,8'd3));
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("hold_abort", packExp(0,0,2'b00,0,0,0,8'd3));

        // Reset mid-run clears the run counter.
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("reset_midrun", idle0);

        // 256 completed runs wrap the 8-bit counter.
        for (int r = 0; r < 256; r++) begin
            applyStimulus(0, 1, 0, 0, 0, 0);
            applyStimulus(0, 0, 0, 0, 0, 0);
            applyStimulus(0, 0, 0, 0, 0, 1);
            applyStimulus(0, 0, 0, 0, 0, 0);
            if (r == 254) checkOutput("runcount_255", packExp(0,0,2'b00,0,0,0,8'd255));
        end
        checkOutput("runcount_wrap", idle0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
